// File: rtl/bram_sdram_emu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bram_sdram_emu_pkg
//  Description : Shared types and default constants for the block-RAM based
//                SDRAM controller emulator. The REFRESH state only exists
//                when BRAM_SDRAM_EMU_REFRESH_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package bram_sdram_emu_pkg;

    localparam int DEF_ADDR_WIDTH     = 16;
    localparam int DEF_INIT_CYCLES    = 100;
    localparam int DEF_READ_LATENCY   = 2;
    localparam int DEF_REFRESH_CYCLES = 7;

    localparam int BUS_ADDR_WIDTH = 25;
    localparam int BURST_WIDTH    = 10;
    localparam int DATA_WIDTH     = 16;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
`ifdef BRAM_SDRAM_EMU_REFRESH_EN
        ST_REFRESH   = 3'd2,
`endif
        ST_WRITE     = 3'd3,
        ST_READ_WAIT = 3'd4,
        ST_READ      = 3'd5,
        ST_PRECHARGE = 3'd6
    } state_e;

    // Index of the last beat of a burst; a request for 0 words moves 1 word.
    function automatic logic [BURST_WIDTH-1:0] burst_last(input logic [BURST_WIDTH-1:0] n);
        return (n == '0) ? '0 : n - BURST_WIDTH'(1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_sdram_emu_if.sv
`default_nettype none
// ============================================================================
//  Module      : bram_sdram_emu_if
//  Description : Request/data bus between a memory user (master) and the
//                SDRAM emulator (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface bram_sdram_emu_if;
    import bram_sdram_emu_pkg::*;

    logic [BUS_ADDR_WIDTH-1:0] address;
    logic [BURST_WIDTH-1:0]    access_num;
    logic [DATA_WIDTH-1:0]     data_in;
    logic [DATA_WIDTH-1:0]     data_out;
    logic                      write_request;
    logic                      read_request;
    logic                      enable_refresh;
    logic                      write_flag;
    logic                      read_flag;
    logic                      idle;
    logic                      refresh_mode;

    modport master (
        output address, access_num, data_in, write_request, read_request, enable_refresh,
        input  data_out, write_flag, read_flag, idle, refresh_mode
    );

    modport slave (
        input  address, access_num, data_in, write_request, read_request, enable_refresh,
        output data_out, write_flag, read_flag, idle, refresh_mode
    );
endinterface
`default_nettype wire

// File: rtl/bram_sdram_emu_mem.sv
`default_nettype none
// ============================================================================
//  Module      : bram_sdram_emu_mem
//  Description : Single-port synchronous 16-bit RAM, one-cycle read latency.
//                Only the read register is reset; the array keeps contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_sdram_emu_mem
    import bram_sdram_emu_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  wire logic                  clock,
    input  wire logic                  reset,
    input  wire logic                  we,
    input  wire logic                  re,
    input  wire logic [ADDR_WIDTH-1:0] addr,
    input  wire logic [DATA_WIDTH-1:0] wdata,
    output logic      [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage array write port, deliberately without reset
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Read register: updates only on a read so the last word is held
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/bram_sdram_emu.sv
`default_nettype none
// ============================================================================
//  Module      : bram_sdram_emu
//  Description : SDRAM controller emulator on block RAM. Init delay, burst
//                writes, latency-delayed burst reads and a precharge cycle.
//                Define BRAM_SDRAM_EMU_REFRESH_EN to build the REFRESH state.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_sdram_emu
    import bram_sdram_emu_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int INIT_CYCLES    = DEF_INIT_CYCLES,
    parameter int READ_LATENCY   = DEF_READ_LATENCY,
    parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
    input  wire logic        clock,
    input  wire logic        reset,
    bram_sdram_emu_if.slave  bus
);

    // Shared down-counter for INIT, READ_WAIT and REFRESH; loaded with length-1.
    localparam int TIMER_MAX = max3(INIT_CYCLES, READ_LATENCY, REFRESH_CYCLES);
    localparam int TW        = (TIMER_MAX < 2) ? 1 : $clog2(TIMER_MAX);

    state_e                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [BURST_WIDTH-1:0] beats_q, beats_d;
    logic [ADDR_WIDTH-1:0]  addr_q,  addr_d;
    logic                   mem_we;
    logic                   mem_re;
    logic [DATA_WIDTH-1:0]  mem_rdata;

    // Next-state, counters and RAM strobes; addr_q always points at the next RAM access
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        beats_d = beats_q;
        addr_d  = addr_q;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_IDLE: begin
`ifdef BRAM_SDRAM_EMU_REFRESH_EN
                if (bus.enable_refresh) begin
                    state_d = ST_REFRESH;
                    timer_d = TW'(REFRESH_CYCLES - 1);
                end else
`endif
                if (bus.write_request) begin
                    state_d = ST_WRITE;
                    addr_d  = bus.address[ADDR_WIDTH-1:0];
                    beats_d = burst_last(bus.access_num);
                end else if (bus.read_request) begin
                    state_d = ST_READ_WAIT;
                    timer_d = TW'(READ_LATENCY - 1);
                    addr_d  = bus.address[ADDR_WIDTH-1:0];
                    beats_d = burst_last(bus.access_num);
                end
            end
`ifdef BRAM_SDRAM_EMU_REFRESH_EN
            ST_REFRESH: begin
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
`endif
            ST_WRITE: begin
                // A reset in this cycle aborts the burst before this word lands
                mem_we = ~reset;
                addr_d = addr_q + ADDR_WIDTH'(1);
                if (beats_q == '0) begin
                    state_d = ST_PRECHARGE;
                end else begin
                    beats_d = beats_q - BURST_WIDTH'(1);
                end
            end
            ST_READ_WAIT: begin
                // Final wait cycle fetches word 0 so it appears with the first read_flag
                if (timer_q == '0) begin
                    mem_re  = 1'b1;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = ST_READ;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_READ: begin
                if (beats_q == '0) begin
                    state_d = ST_PRECHARGE;
                end else begin
                    mem_re  = 1'b1;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    beats_d = beats_q - BURST_WIDTH'(1);
                end
            end
            ST_PRECHARGE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
                timer_d = TW'(INIT_CYCLES - 1);
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_INIT;
            timer_q <= TW'(INIT_CYCLES - 1);
            beats_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            beats_q <= beats_d;
            addr_q  <= addr_d;
        end
    end

    bram_sdram_emu_mem #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clock (clock),
        .reset (reset),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (addr_q),
        .wdata (bus.data_in),
        .rdata (mem_rdata)
    );

    assign bus.data_out   = mem_rdata;
    assign bus.write_flag = (state_q == ST_WRITE);
    assign bus.read_flag  = (state_q == ST_READ);
    assign bus.idle       = (state_q == ST_IDLE);

`ifdef BRAM_SDRAM_EMU_REFRESH_EN
    assign bus.refresh_mode = (state_q == ST_REFRESH);
`else
    assign bus.refresh_mode = 1'b0;
    logic unused_enable_refresh;
    assign unused_enable_refresh = bus.enable_refresh;
`endif

    generate
        if (ADDR_WIDTH < BUS_ADDR_WIDTH) begin : g_addr_hi_unused
            logic unused_addr_hi;
            assign unused_addr_hi = ^bus.address[BUS_ADDR_WIDTH-1:ADDR_WIDTH];
        end
    endgenerate

endmodule
`default_nettype wire
